up_down_mod_counter: RTL

Parametrised up/down counter, successor to the fixed 16-bit up/down counter.
- Adds: programmable WIDTH, runtime modulus (max_val), runtime step, wrap/saturate mode, terminal-count pulse, sticky overflow/underflow flags.
- Used as the general counting primitive for timers, address generators and event counters in the datapath. Its property module is bound alongside it.

---
 rtl/up_down_cnt_pkg.sv | 13 +
 rtl/up_down_cnt_next.sv | 47 ++++
 rtl/up_down_mod_counter.sv | 69 ++++++
 3 files changed

// File: rtl/up_down_cnt_pkg.sv
// Shared types and defaults for the parametrised up/down modulus counter.
// Imported by the counter top and its next-value calculator.
package up_down_cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_RST_VAL = 0;

endpackage

// File: rtl/up_down_cnt_next.sv
// Combinational next-count calculator: produces the value the counter would
// take on an enabled count, plus the overflow/underflow boundary events.
module up_down_cnt_next
    import up_down_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max_val,
    input  logic             updn_cnt,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf_evt,
    output logic             unf_evt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    // The extra sum bit keeps a carry out of WIDTH visible to the bound check,
    // so a sum past 2^WIDTH-1 still reads as exceeding max_val.
    always_comb begin
        sum     = {1'b0, data_out} + {1'b0, step};
        diff    = data_out - step;
        nxt     = data_out;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;

        if (updn_cnt) begin
            if (sum > {1'b0, max_val}) begin
                ovf_evt = 1'b1;
                nxt     = (mode == CNT_SAT) ? max_val : '0;
            end else begin
                nxt = sum[WIDTH-1:0];
            end
        end else begin
            if (step > data_out) begin
                unf_evt = 1'b1;
                nxt     = (mode == CNT_SAT) ? '0 : max_val;
            end else begin
                nxt = diff;
            end
        end
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// Parametrised up/down counter with runtime modulus and step, wrap/saturate
// mode, one-cycle terminal-count pulse and sticky overflow/underflow flags.
module up_down_mod_counter
    import up_down_cnt_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_enb,
    input  logic             updn_cnt,
    input  logic             ld_cnt,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] step,
    input  cnt_mode_e        mode,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] nxt;
    logic             ovf_evt;
    logic             unf_evt;
    logic             do_count;

    up_down_cnt_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .data_out (data_out),
        .step     (step),
        .max_val  (max_val),
        .updn_cnt (updn_cnt),
        .mode     (mode),
        .nxt      (nxt),
        .ovf_evt  (ovf_evt),
        .unf_evt  (unf_evt)
    );

    assign do_count = count_enb && (step != '0);

    // Flag clear is applied first so a coinciding boundary event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= RST_VAL;
            tc       <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clr_flags) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (ld_cnt) begin
                data_out <= (data_in > max_val) ? max_val : data_in;
            end else if (do_count) begin
                data_out <= nxt;
                tc       <= ovf_evt | unf_evt;
                if (ovf_evt) ovf <= 1'b1;
                if (unf_evt) unf <= 1'b1;
            end
        end
    end

endmodule
